uart_sched: RTL and testbench

- Bus-master sequencer that owns the UART register port (RECV 0x4, SEND 0x8, STATUS 0xC) and hides polling from the rest of the design.
- Buffers outgoing bytes in a TX FIFO and incoming bytes in an RX FIFO.
- Repeatedly polls STATUS, issues SEND writes and RECV reads itself, and presents byte-stream valid/ready interfaces to the core side.
- Sits between the system interconnect and the UART peripheral, in the clk_bus domain.

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_fifo.sv | 51 +++++
 rtl/uart_sched.sv | 139 +++++++++++++
 tb/tb_uart_sched.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and state type for the UART scheduler.
package uart_pkg;

   localparam logic [3:0] UART_REG_RECV   = 4'h4;
   localparam logic [3:0] UART_REG_SEND   = 4'h8;
   localparam logic [3:0] UART_REG_STATUS = 4'hC;

   localparam int ST_TX_IDLE  = 0;
   localparam int ST_RX_AVAIL = 1;

   typedef enum logic [1:0] {
      POLL  = 2'd0,
      RECV  = 2'd1,
      SEND  = 2'd2,
      GUARD = 2'd3
   } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. A push into a full FIFO is
// accepted when a pop happens in the same cycle; head reads 0 when empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk_bus,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic [WIDTH-1:0]         head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == FULL_LVL);
   assign empty   = (level == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? '0 : mem[rd_ptr];

   // pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
   always_ff @(posedge clk_bus or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // storage write
   always_ff @(posedge clk_bus) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_sched.sv
// UART register-port sequencer: polls STATUS, drains RECV into an RX FIFO
// and feeds SEND from a TX FIFO.
// Optional macro UART_SCHED_RX_DROP_EN: keep reading RECV while the RX FIFO
// is full, discarding the byte and setting the sticky rx_overflow flag.
//
//   state | meaning
//   POLL  | read STATUS, choose next operation (RX before TX)
//   RECV  | read RECV, push byte into RX FIFO
//   SEND  | write TX head to SEND, pop TX FIFO
//   GUARD | strobe-free wait so tx_idle can settle before the next poll
module uart_sched
   import uart_pkg::*;
#(
   parameter int TX_DEPTH = 8,
   parameter int RX_DEPTH = 8,
   parameter int TX_GUARD = 4
) (
   input  logic                        clk_bus,
   input  logic                        rst,
   input  logic [7:0]                  tx_data,
   input  logic                        tx_valid,
   output logic                        tx_ready,
   output logic [7:0]                  rx_data,
   output logic                        rx_valid,
   input  logic                        rx_ready,
   output logic [$clog2(TX_DEPTH):0]   tx_level,
   output logic [$clog2(RX_DEPTH):0]   rx_level,
   output logic                        rx_overflow,
   output logic [3:0]                  uart_address,
   output logic [31:0]                 uart_data_o,
   input  logic [31:0]                 uart_data_i,
   output logic                        uart_read,
   output logic                        uart_write
);

   localparam int GW = $clog2(TX_GUARD + 1);

   state_t        state;
   logic [GW-1:0] gcnt;
   logic          tx_full, tx_empty, rx_full, rx_empty;
   logic [7:0]    tx_head;
   logic          tx_push, rx_pop, rx_take;
   logic          unused_data;

   assign tx_ready    = !tx_full;
   assign rx_valid    = !rx_empty;
   assign tx_push     = tx_valid && tx_ready;
   assign rx_pop      = rx_ready && rx_valid;
   assign unused_data = &{1'b0, uart_data_i[31:8]};

   sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk_bus (clk_bus),
      .rst     (rst),
      .push    (tx_push),
      .pop     (state == SEND),
      .din     (tx_data),
      .full    (tx_full),
      .empty   (tx_empty),
      .level   (tx_level),
      .head    (tx_head)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk_bus (clk_bus),
      .rst     (rst),
      .push    (state == RECV),
      .pop     (rx_pop),
      .din     (uart_data_i[7:0]),
      .full    (rx_full),
      .empty   (rx_empty),
      .level   (rx_level),
      .head    (rx_data)
   );

`ifdef UART_SCHED_RX_DROP_EN
   assign rx_take = uart_data_i[ST_RX_AVAIL];

   // a RECV into a full FIFO with no same-cycle pop loses its byte
   always_ff @(posedge clk_bus or posedge rst) begin
      if (rst)                                      rx_overflow <= 1'b0;
      else if (state == RECV && rx_full && !rx_pop) rx_overflow <= 1'b1;
   end
`else
   assign rx_take     = uart_data_i[ST_RX_AVAIL] && !rx_full;
   assign rx_overflow = 1'b0;
`endif

   // operation sequencing and guard down-counter
   always_ff @(posedge clk_bus or posedge rst) begin
      if (rst) begin
         state <= POLL;
         gcnt  <= '0;
      end else begin
         case (state)
            POLL: begin
               if (rx_take)                                     state <= RECV;
               else if (uart_data_i[ST_TX_IDLE] && !tx_empty)   state <= SEND;
            end
            RECV: state <= POLL;
            SEND: begin
               state <= GUARD;
               gcnt  <= GW'(TX_GUARD - 1);
            end
            GUARD: begin
               if (gcnt == '0) state <= POLL;
               else            gcnt  <= gcnt - GW'(1);
            end
            default: state <= POLL;
         endcase
      end
   end

   // bus strobes; reset forces them low without waiting for a clock edge
   always_comb begin
      uart_read    = 1'b0;
      uart_write   = 1'b0;
      uart_address = 4'h0;
      uart_data_o  = 32'h0;
      if (!rst) begin
         case (state)
            POLL: begin
               uart_read    = 1'b1;
               uart_address = UART_REG_STATUS;
            end
            RECV: begin
               uart_read    = 1'b1;
               uart_address = UART_REG_RECV;
            end
            SEND: begin
               uart_write   = 1'b1;
               uart_address = UART_REG_SEND;
               uart_data_o  = {24'h0, tx_head};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_sched.sv
// Randomized bench for uart_sched against a queue-based behavioural model.
module tb_uart_sched;

   localparam int TXD = 8;
   localparam int RXD = 8;
   localparam int TXG = 4;
`ifdef UART_SCHED_RX_DROP_EN
   localparam bit DROP = 1'b1;
`else
   localparam bit DROP = 1'b0;
`endif

   logic        clk_bus = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  tx_data = 8'h0;
   logic        tx_valid = 1'b0;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready = 1'b0;
   logic [3:0]  tx_level;
   logic [3:0]  rx_level;
   logic        rx_overflow;
   logic [3:0]  uart_address;
   logic [31:0] uart_data_o;
   logic [31:0] uart_data_i;
   logic        uart_read;
   logic        uart_write;

   logic [1:0]  status = 2'b01;
   logic [7:0]  rbyte  = 8'h00;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // model state: ph 0=POLL 1=RECV 2=SEND 3=GUARD
   int         ph = 0;
   int         gc = 0;
   bit         ovf = 1'b0;
   logic [7:0] txq[$];
   logic [7:0] rxq[$];

   logic [7:0] wlog[$];
   int         wcyc[$];
   int         first_r = -1;
   int         n_recv = 0;

   always #5 clk_bus = ~clk_bus;

   assign uart_data_i = (uart_address == 4'hC) ? {30'h15555554, status} :
                        (uart_address == 4'h4) ? {24'hA5A5A5, rbyte} : 32'h0;

   uart_sched #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .TX_GUARD(TXG)) dut (
      .clk_bus      (clk_bus),
      .rst          (rst),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .tx_level     (tx_level),
      .rx_level     (rx_level),
      .rx_overflow  (rx_overflow),
      .uart_address (uart_address),
      .uart_data_o  (uart_data_o),
      .uart_data_i  (uart_data_i),
      .uart_read    (uart_read),
      .uart_write   (uart_write)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_outputs();
      logic [3:0] ea;
      ea = (ph == 0) ? 4'hC : (ph == 1) ? 4'h4 : 4'h8;
      chk("uart_read",  uart_read,  (ph == 0 || ph == 1));
      chk("uart_write", uart_write, (ph == 2));
      if (ph != 3) chk("uart_address", uart_address, ea);
      if (ph == 2) chk("uart_data_o", uart_data_o, {24'h0, txq[0]});
      chk("tx_ready", tx_ready, (txq.size() < TXD));
      chk("tx_level", tx_level, txq.size());
      chk("rx_valid", rx_valid, (rxq.size() > 0));
      chk("rx_level", rx_level, rxq.size());
      chk("rx_overflow", rx_overflow, ovf);
      if (rxq.size() > 0) chk("rx_data", rx_data, rxq[0]);
      if (uart_write) begin
         wlog.push_back(uart_data_o[7:0]);
         wcyc.push_back(cyc);
      end
      if (uart_read && uart_address == 4'h4) begin
         n_recv++;
         if (first_r < 0) first_r = cyc;
      end
   endtask

   task automatic model_update();
      int  txn, rxn, nph;
      bit  txp, rxp;
      txn = txq.size();
      rxn = rxq.size();
      txp = tx_valid && (txn < TXD);
      rxp = rx_ready && (rxn > 0);
      nph = ph;
      case (ph)
         0: begin
            if (status[1] && (rxn < RXD || DROP)) nph = 1;
            else if (status[0] && txn > 0)        nph = 2;
            else                                  nph = 0;
         end
         1: nph = 0;
         2: begin nph = 3; gc = TXG - 1; end
         default: begin
            if (gc == 0) nph = 0;
            else         gc--;
         end
      endcase
      if (rxp) void'(rxq.pop_front());
      if (ph == 1) begin
         if (rxn < RXD || rxp) rxq.push_back(rbyte);
         else                  ovf = 1'b1;
      end
      if (ph == 2) void'(txq.pop_front());
      if (txp) txq.push_back(tx_data);
      ph = nph;
   endtask

   // called at a negedge with inputs already set; returns at the next negedge
   task automatic step();
      #1;
      check_outputs();
      @(posedge clk_bus);
      model_update();
      @(negedge clk_bus);
      cyc++;
   endtask

   task automatic check_reset_outputs();
      chk("rst_uart_read",  uart_read,    1'b0);
      chk("rst_uart_write", uart_write,   1'b0);
      chk("rst_address",    uart_address, 4'h0);
      chk("rst_data_o",     uart_data_o,  32'h0);
      chk("rst_tx_ready",   tx_ready,     1'b1);
      chk("rst_rx_valid",   rx_valid,     1'b0);
      chk("rst_tx_level",   tx_level,     4'h0);
      chk("rst_rx_level",   rx_level,     4'h0);
      chk("rst_overflow",   rx_overflow,  1'b0);
      chk("rst_rx_data",    rx_data,      8'h0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tx_valid = 1'b0;
      rx_ready = 1'b0;
      repeat (3) begin
         #1;
         check_reset_outputs();
         @(negedge clk_bus);
      end
      txq.delete();
      rxq.delete();
      ph  = 0;
      gc  = 0;
      ovf = 1'b0;
      rst = 1'b0;
   endtask

   initial begin
      int t;
      @(negedge clk_bus);
      do_reset();

      // idle UART: continuous STATUS polling, no writes
      status = 2'b01;
      wlog.delete();
      repeat (12) step();
      chk("idle_no_write", wlog.size(), 0);

      // two bytes with tx_idle set: write order and guard spacing
      wlog.delete();
      wcyc.delete();
      tx_valid = 1'b1; tx_data = 8'h41; step();
      tx_data = 8'h42; step();
      tx_valid = 1'b0;
      repeat (20) step();
      chk("two_write_count", wlog.size(), 2);
      if (wlog.size() == 2) begin
         chk("first_write", wlog[0], 8'h41);
         chk("second_write", wlog[1], 8'h42);
         chk("write_spacing", wcyc[1] - wcyc[0], TXG + 2);
      end
      chk("two_tx_level", tx_level, 4'h0);

      // RX priority over pending TX
      status = 2'b00;
      wlog.delete();
      wcyc.delete();
      first_r = -1;
      tx_valid = 1'b1; tx_data = 8'h77; step();
      tx_valid = 1'b0; step();
      status = 2'b11; rbyte = 8'h5A; step(); step();
      status = 2'b01;
      repeat (12) step();
      chk("prio_recv_seen", (first_r >= 0), 1'b1);
      chk("prio_write_seen", (wcyc.size() > 0), 1'b1);
      if (first_r >= 0 && wcyc.size() > 0) chk("prio_order", (first_r < wcyc[0]), 1'b1);
      rx_ready = 1'b1;
      repeat (6) step();

      // RX full with rx_avail held high
      rx_ready = 1'b0;
      status = 2'b10;
      for (int i = 0; i < 3 * RXD + 6; i++) begin
         rbyte = 8'(i + 8'h30);
         step();
      end
      n_recv = 0;
      repeat (10) step();
      chk("full_recv_reads", (n_recv != 0), DROP);
      chk("full_rx_level", rx_level, RXD);
      chk("full_overflow", rx_overflow, DROP);
      status = 2'b00;
      rx_ready = 1'b1;
      repeat (RXD + 4) step();

      // nine pushes with tx_idle low: only TXD accepted
      do_reset();
      status = 2'b00;
      tx_valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tx_data = 8'(8'h60 + i);
         step();
      end
      tx_valid = 1'b0;
      step();
      chk("nine_tx_level", tx_level, TXD);
      chk("nine_tx_ready", tx_ready, 1'b0);

      // reset asserted during GUARD with three bytes queued
      do_reset();
      status = 2'b00;
      tx_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tx_data = 8'(8'h90 + i);
         step();
      end
      tx_valid = 1'b0;
      status = 2'b01;
      t = 0;
      while (ph != 3 && t < 20) begin
         step();
         t++;
      end
      chk("guard_reached", (ph == 3), 1'b1);
      chk("guard_queued", tx_level, 4'h3);
      rst = 1'b1;
      #1;
      chk("guard_rst_read", uart_read, 1'b0);
      chk("guard_rst_write", uart_write, 1'b0);
      chk("guard_rst_level", tx_level, 4'h0);
      @(negedge clk_bus);
      do_reset();
      #1;
      chk("post_rst_poll", uart_address, 4'hC);
      chk("post_rst_read", uart_read, 1'b1);
      @(negedge clk_bus);
      step();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         status   = 2'($urandom_range(0, 3));
         rbyte    = 8'($urandom);
         tx_valid = ($urandom_range(0, 99) < 40);
         tx_data  = 8'($urandom);
         rx_ready = ($urandom_range(0, 99) < 60);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
